// File: rtl/sdram_req_arb.sv
// Request arbiter in front of the SDRAM command engine: periodic auto-refresh plus
// alternating user write/read, one operation in flight at a time over valid/ready.
module sdram_req_arb #(
  parameter logic [15:0] REFRESH_PERIOD = 16'd780,
  parameter int unsigned ADDR_W         = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [1:0]        op_code,
  output logic [1:0]        op_bank,
  output logic [11:0]       op_row,
  output logic [7:0]        op_col,
  input  logic              op_done,
  output logic              ref_missed
);

  localparam int unsigned COL_W  = 8;
  localparam int unsigned ROW_W  = 12;
  localparam int unsigned BANK_W = 2;
  localparam int unsigned CNT_W  = 16;

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_REF = 2'd1;
  localparam logic [1:0] OP_WR  = 2'd2;
  localparam logic [1:0] OP_RD  = 2'd3;

  typedef enum logic [1:0] {WAIT_INIT, IDLE, ISSUE, BUSY} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   ref_cnt;
  logic               ref_pending;
  logic               last_wr, last_wr_n;
  logic               op_valid_n;
  logic [1:0]         op_code_n;
  logic [BANK_W-1:0]  op_bank_n;
  logic [ROW_W-1:0]   op_row_n;
  logic [COL_W-1:0]   op_col_n;

  logic               wrap_c;
  logic               xfer_c;
  logic               ref_xfer_c;

  assign wrap_c     = (state != WAIT_INIT) && (ref_cnt == REFRESH_PERIOD - 16'd1);
  assign xfer_c     = op_valid && op_ready;
  assign ref_xfer_c = xfer_c && (op_code == OP_REF);

  // Acks mark the handshake itself, so they share the transfer cycle.
  assign wr_ack = xfer_c && (op_code == OP_WR);
  assign rd_ack = xfer_c && (op_code == OP_RD);

  // Next state and next values of the operation registers
  always_comb begin
    state_n    = state;
    last_wr_n  = last_wr;
    op_valid_n = op_valid;
    op_code_n  = op_code;
    op_bank_n  = op_bank;
    op_row_n   = op_row;
    op_col_n   = op_col;
    case (state)
      WAIT_INIT: begin
        if (init_done) state_n = IDLE;
      end
      IDLE: begin
        if (ref_pending) begin
          state_n    = ISSUE;
          op_valid_n = 1'b1;
          op_code_n  = OP_REF;
          op_bank_n  = '0;
          op_row_n   = '0;
          op_col_n   = '0;
        end else if (wr_req && (!rd_req || !last_wr)) begin
          state_n    = ISSUE;
          op_valid_n = 1'b1;
          op_code_n  = OP_WR;
          op_bank_n  = wr_addr[COL_W+ROW_W+BANK_W-1:COL_W+ROW_W];
          op_row_n   = wr_addr[COL_W+ROW_W-1:COL_W];
          op_col_n   = wr_addr[COL_W-1:0];
        end else if (rd_req) begin
          state_n    = ISSUE;
          op_valid_n = 1'b1;
          op_code_n  = OP_RD;
          op_bank_n  = rd_addr[COL_W+ROW_W+BANK_W-1:COL_W+ROW_W];
          op_row_n   = rd_addr[COL_W+ROW_W-1:COL_W];
          op_col_n   = rd_addr[COL_W-1:0];
        end
      end
      ISSUE: begin
        if (xfer_c) begin
          state_n    = BUSY;
          op_valid_n = 1'b0;
          op_code_n  = OP_NOP;
          if (op_code == OP_WR)      last_wr_n = 1'b1;
          else if (op_code == OP_RD) last_wr_n = 1'b0;
        end
      end
      BUSY: begin
        if (op_done) state_n = IDLE;
      end
      default: state_n = WAIT_INIT;
    endcase
  end

  // State, refresh bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_INIT;
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
      ref_missed  <= 1'b0;
      last_wr     <= 1'b0;
      op_valid    <= 1'b0;
      op_code     <= OP_NOP;
      op_bank     <= '0;
      op_row      <= '0;
      op_col      <= '0;
    end else begin
      state    <= state_n;
      last_wr  <= last_wr_n;
      op_valid <= op_valid_n;
      op_code  <= op_code_n;
      op_bank  <= op_bank_n;
      op_row   <= op_row_n;
      op_col   <= op_col_n;
      if (state != WAIT_INIT) ref_cnt <= wrap_c ? '0 : ref_cnt + CNT_W'(1);
      // A wrap coinciding with the REF transfer re-arms the request rather than missing it
      if (wrap_c)          ref_pending <= 1'b1;
      else if (ref_xfer_c) ref_pending <= 1'b0;
      if (wrap_c && ref_pending && !ref_xfer_c) ref_missed <= 1'b1;
    end
  end

endmodule
